// File: rtl/mio_pkg.sv
// Shared address map, bus target and controller state types for the MIO bus controller.
// The counter target is only produced when MIO_COUNTER_EN is defined.
package mio_pkg;

    localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] DISP_ADDR = 32'hE000_0000;
    localparam logic [31:0] GPIO_ADDR = 32'hF000_0000;
    localparam logic [31:0] CNT_ADDR  = 32'hF000_0004;

    typedef enum logic [2:0] {
        TGT_RAM,
        TGT_DISP,
        TGT_GPIO,
        TGT_CNT,
        TGT_NONE
    } target_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mio_bus_ctrl_decode.sv
// Combinational address decoder: byte address -> bus target and RAM word address.
// With MIO_COUNTER_EN undefined the counter address decodes as unmapped.
module mio_addr_decode
    import mio_pkg::*;
#(
    parameter int unsigned RAM_AW = 10
) (
    input  logic [31:0]       addr,
    output target_t           target,
    output logic [RAM_AW-1:0] word_addr
);

    logic [31:0] aligned;

    always_comb begin
        aligned   = word_align(addr);
        target    = TGT_NONE;
        word_addr = addr[RAM_AW+1:2];
        // RAM occupies the low 4*2^RAM_AW bytes: every bit above the word range must match the base
        if (((aligned ^ RAM_BASE) >> (RAM_AW + 2)) == 32'd0) begin
            target = TGT_RAM;
        end else if (aligned == DISP_ADDR) begin
            target = TGT_DISP;
        end else if (aligned == GPIO_ADDR) begin
            target = TGT_GPIO;
`ifdef MIO_COUNTER_EN
        end else if (aligned == CNT_ADDR) begin
            target = TGT_CNT;
`endif
        end
    end

endmodule

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller: decodes CPU requests to RAM, GPIO and display, inserts RAM wait states.
// Define MIO_COUNTER_EN to add a free-running 32-bit counter at 0xF000_0004.
module mio_bus_ctrl
    import mio_pkg::*;
#(
    parameter int unsigned RAM_AW  = 10,
    parameter int unsigned RAM_LAT = 2,
    parameter int unsigned LED_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_mio,
    input  logic              mem_w,
    input  logic [31:0]       addr_in,
    input  logic [31:0]       data_from_cpu,
    output logic [31:0]       data_to_cpu,
    output logic              mio_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_we,
    input  logic [31:0]       ram_dout,
    input  logic [15:0]       sw_in,
    output logic [LED_W-1:0]  led_out,
    output logic [31:0]       disp_out
);

    localparam logic [3:0] LAT_M1 = 4'(RAM_LAT - 1);

    state_t            state;
    target_t           tgt_q;
    logic              wr_q;
    logic [3:0]        wait_cnt;
    target_t           dec_tgt;
    logic [RAM_AW-1:0] dec_word;
    logic [31:0]       rd_mux;
    logic              last_access;
    logic [31:0]       cnt_val;

    mio_addr_decode #(
        .RAM_AW(RAM_AW)
    ) u_decode (
        .addr     (addr_in),
        .target   (dec_tgt),
        .word_addr(dec_word)
    );

    assign last_access = (state == S_ACCESS) && (wait_cnt == 4'd0);

`ifdef MIO_COUNTER_EN
    logic [31:0] cnt_q;

    // A committed write takes priority over the increment in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (last_access && wr_q && (tgt_q == TGT_CNT)) begin
            cnt_q <= ram_din;
        end else begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign cnt_val = cnt_q;
`else
    assign cnt_val = '0;
`endif

    always_comb begin
        rd_mux = '0;
        case (tgt_q)
            TGT_RAM:  rd_mux = ram_dout;
            TGT_DISP: rd_mux = disp_out;
            TGT_GPIO: rd_mux = {16'h0000, sw_in};
            TGT_CNT:  rd_mux = cnt_val;
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            tgt_q       <= TGT_NONE;
            wr_q        <= 1'b0;
            wait_cnt    <= '0;
            ram_addr    <= '0;
            ram_din     <= '0;
            ram_we      <= 1'b0;
            mio_ready   <= 1'b0;
            data_to_cpu <= '0;
            led_out     <= '0;
            disp_out    <= '0;
        end else begin
            ram_we    <= 1'b0;
            mio_ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cpu_mio) begin
                        tgt_q    <= dec_tgt;
                        wr_q     <= mem_w;
                        ram_addr <= dec_word;
                        ram_din  <= data_from_cpu;
                        // Strobe lands in the first ACCESS cycle only
                        ram_we   <= mem_w && (dec_tgt == TGT_RAM);
                        wait_cnt <= (dec_tgt == TGT_RAM) ? LAT_M1 : 4'd0;
                        state    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        if (!wr_q) begin
                            data_to_cpu <= rd_mux;
                        end else begin
                            case (tgt_q)
                                TGT_DISP: disp_out <= ram_din;
                                TGT_GPIO: led_out  <= ram_din[LED_W-1:0];
                                default:  ;
                            endcase
                        end
                        mio_ready <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Directed bench for mio_bus_ctrl: table of single transactions plus reset, back-to-back and counter sequences.
// Counter expectations follow MIO_COUNTER_EN as compiled.
module tb_mio_bus_ctrl;
    import mio_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_mio;
    logic        mem_w;
    logic [31:0] addr_in;
    logic [31:0] data_from_cpu;
    logic [31:0] data_to_cpu;
    logic        mio_ready;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din;
    logic        ram_we;
    logic [31:0] ram_dout;
    logic [15:0] sw_in;
    logic [7:0]  led_out;
    logic [31:0] disp_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int we_cnt = 0;
    int we_first = -1;
    int we_last = -1;

    logic [31:0] mem [0:1023];

    mio_bus_ctrl #(
        .RAM_AW (10),
        .RAM_LAT(2),
        .LED_W  (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_mio      (cpu_mio),
        .mem_w        (mem_w),
        .addr_in      (addr_in),
        .data_from_cpu(data_from_cpu),
        .data_to_cpu  (data_to_cpu),
        .mio_ready    (mio_ready),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .ram_we       (ram_we),
        .ram_dout     (ram_dout),
        .sw_in        (sw_in),
        .led_out      (led_out),
        .disp_out     (disp_out)
    );

    always #5 clk = ~clk;

    assign ram_dout = mem[ram_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_we) begin
            mem[ram_addr] <= ram_din;
            we_cnt = we_cnt + 1;
            if (we_first < 0) we_first = int'(ram_addr);
            we_last = int'(ram_addr);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issues one request, waits for mio_ready (bounded), returns latency, read data and accept edge index
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rdata, output int acc);
        @(negedge clk);
        cpu_mio       = 1'b1;
        mem_w         = w;
        addr_in       = a;
        data_from_cpu = d;
        @(posedge clk);
        lat   = 0;
        rdata = 'x;
        acc   = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) acc = cyc;
            if (mio_ready) begin
                lat   = k;
                rdata = data_to_cpu;
                break;
            end
        end
        cpu_mio = 1'b0;
    endtask

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [15:0] sw;
        int          lat;
        logic [31:0] rd;
        logic [7:0]  led;
        logic [31:0] disp;
        int          we;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int          lat;
        int          acc;
        int          wacc;
        int          racc;
        int          gap;
        logic [31:0] rdata;
        logic        seen;
        logic [31:0] exp_cnt;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 16'h0000, 3, 32'h0000_0000, 8'h00, 32'h0000_0000, 1};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 16'h0000, 3, 32'hDEADBEEF, 8'h00, 32'h0000_0000, 1};
        vecs[2]  = '{1'b0, 32'hF000_0000, 32'h0000_0000, 16'h00A5, 2, 32'h0000_00A5, 8'h00, 32'h0000_0000, 1};
        vecs[3]  = '{1'b1, 32'hF000_0000, 32'h0000_01FF, 16'h00A5, 2, 32'h0000_00A5, 8'hFF, 32'h0000_0000, 1};
        vecs[4]  = '{1'b1, 32'hE000_0000, 32'h1234_5678, 16'h00A5, 2, 32'h0000_00A5, 8'hFF, 32'h1234_5678, 1};
        vecs[5]  = '{1'b0, 32'h8000_0000, 32'h0000_0000, 16'h00A5, 2, 32'h0000_0000, 8'hFF, 32'h1234_5678, 1};
        vecs[6]  = '{1'b0, 32'hE000_0002, 32'h0000_0000, 16'h00A5, 2, 32'h1234_5678, 8'hFF, 32'h1234_5678, 1};
        vecs[7]  = '{1'b0, 32'h0000_0013, 32'h0000_0000, 16'h00A5, 3, 32'hDEADBEEF, 8'hFF, 32'h1234_5678, 1};
        vecs[8]  = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 16'h00A5, 3, 32'hDEADBEEF, 8'hFF, 32'h1234_5678, 2};
        vecs[9]  = '{1'b0, 32'h0000_0FFC, 32'h0000_0000, 16'h00A5, 3, 32'hCAFE_F00D, 8'hFF, 32'h1234_5678, 2};
        vecs[10] = '{1'b0, 32'h0000_1000, 32'h0000_0000, 16'h00A5, 2, 32'h0000_0000, 8'hFF, 32'h1234_5678, 2};
        vecs[11] = '{1'b1, 32'hF000_0008, 32'h0000_0055, 16'h00A5, 2, 32'h0000_0000, 8'hFF, 32'h1234_5678, 2};
        vecs[12] = '{1'b1, 32'h0000_1000, 32'h0000_0077, 16'h00A5, 2, 32'h0000_0000, 8'hFF, 32'h1234_5678, 2};

        reset = 1'b1; cpu_mio = 1'b0; mem_w = 1'b0; addr_in = '0; data_from_cpu = '0; sw_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_data", data_to_cpu, 32'h0);
        chk("rst_ready", 32'(mio_ready), 32'h0);
        chk("rst_we", 32'(ram_we), 32'h0);
        chk("rst_led", 32'(led_out), 32'h0);
        chk("rst_disp", disp_out, 32'h0);
        chk("rst_raddr", 32'(ram_addr), 32'h0);
        chk("rst_rdin", ram_din, 32'h0);

        for (int i = 0; i < 13; i++) begin
            sw_in = vecs[i].sw;
            xfer(vecs[i].w, vecs[i].addr, vecs[i].wdata, lat, rdata, acc);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_data", i), rdata, vecs[i].rd);
            chk($sformatf("v%0d_led", i), 32'(led_out), 32'(vecs[i].led));
            chk($sformatf("v%0d_disp", i), disp_out, vecs[i].disp);
            chk($sformatf("v%0d_wecnt", i), 32'(we_cnt), 32'(vecs[i].we));
        end
        chk("we_first_addr", 32'(we_first), 32'd4);
        chk("we_last_addr", 32'(we_last), 32'd1023);

        // Reset during the ACCESS cycle of a display write
        @(negedge clk);
        cpu_mio = 1'b1; mem_w = 1'b1; addr_in = 32'hE000_0000; data_from_cpu = 32'hAAAA_5555;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1; cpu_mio = 1'b0;
        #1;
        chk("midrst_disp", disp_out, 32'h0);
        chk("midrst_led", 32'(led_out), 32'h0);
        chk("midrst_ready", 32'(mio_ready), 32'h0);
        chk("midrst_state", 32'(dut.state == S_IDLE), 32'h1);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | mio_ready;
        end
        chk("midrst_no_ready", 32'(seen), 32'h0);
        chk("midrst_no_commit", disp_out, 32'h0);
        xfer(1'b1, 32'hE000_0000, 32'h0BAD_CAFE, lat, rdata, acc);
        chk("postrst_lat", 32'(lat), 32'd2);
        chk("postrst_disp", disp_out, 32'h0BAD_CAFE);

        // cpu_mio held high across two requests
        @(negedge clk);
        sw_in = 16'h1234; cpu_mio = 1'b1; mem_w = 1'b0; addr_in = 32'hF000_0000;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mio_ready) begin
                lat = k;
                rdata = data_to_cpu;
                break;
            end
        end
        chk("b2b_lat1", 32'(lat), 32'd2);
        chk("b2b_data1", rdata, 32'h0000_1234);
        addr_in = 32'hE000_0000;
        gap = 0;
        seen = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) seen = mio_ready;
            if (mio_ready && k > 1) begin
                gap = k;
                rdata = data_to_cpu;
                break;
            end
        end
        cpu_mio = 1'b0;
        chk("b2b_idle_gap", 32'(seen), 32'h0);
        chk("b2b_lat2", 32'(gap), 32'd3);
        chk("b2b_data2", rdata, 32'h0BAD_CAFE);
        @(negedge clk);
        chk("b2b_pulse_width", 32'(mio_ready), 32'h0);

        // Counter at 0xF000_0004
        xfer(1'b1, 32'hF000_0004, 32'h0000_0100, lat, rdata, wacc);
        chk("cnt_wr_lat", 32'(lat), 32'd2);
        repeat (4) @(negedge clk);
        xfer(1'b0, 32'hF000_0004, 32'h0, lat, rdata, racc);
        chk("cnt_rd_lat", 32'(lat), 32'd2);
`ifdef MIO_COUNTER_EN
        exp_cnt = 32'h100 + 32'(racc - wacc - 1);
`else
        exp_cnt = 32'h0;
`endif
        chk("cnt_rd_data", rdata, exp_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mio_bus_ctrl.md
Name: mio_bus_ctrl

Overview:
- Memory/IO bus controller directly downstream of the multicycle CPU.
- Consumes the CPU's bus request (CPU_MIO, mem_w, Addr_out, Data_out) and returns read data plus the MIO_ready handshake.
- Decodes each request to data RAM, the LED/switch GPIO, or the 7-segment display register, and inserts RAM wait states.
- Makes the CPU's MIO_ready stalls real rather than tied high.

Parameters:
- RAM_AW, 10, RAM word-address width (2^RAM_AW 32-bit words).
- RAM_LAT, 2, RAM access cycles, legal range 1..15.
- LED_W, 8, LED output width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_mio  in  1  CPU bus request
- mem_w  in  1  1 = write, 0 = read
- addr_in  in  32  CPU byte address
- data_from_cpu  in  32  write data
- data_to_cpu  out  32  read data, valid while mio_ready = 1
- mio_ready  out  1  one-cycle completion pulse
- ram_addr  out  RAM_AW  RAM word address
- ram_din  out  32  RAM write data
- ram_we  out  1  RAM write strobe
- ram_dout  in  32  RAM read data, valid in the last ACCESS cycle
- sw_in  in  16  switch inputs
- led_out  out  LED_W  LED register
- disp_out  out  32  7-segment display register

Behaviour:
- Address map, decided on word-aligned addr_in (addr_in[1:0] ignored):
  - 0x0000_0000–(4·2^RAM_AW − 1): RAM, ram_addr = addr[RAM_AW+1:2].
  - 0xE000_0000: DISP. Write loads disp_out; read returns disp_out.
  - 0xF000_0000: GPIO. Write loads led_out = data[LED_W-1:0]; read returns {16'b0, sw_in}.
  - 0xF000_0004: counter (see Optional Feature).
  - Anything else: read returns 0, write is ignored, the handshake still completes (the bus never hangs).
- State machine: IDLE → ACCESS → RESP → IDLE.
- IDLE:
  - If cpu_mio = 1, latch addr_in, data_from_cpu, mem_w and the decoded target.
  - Load the wait counter with RAM_LAT−1 for RAM, 0 otherwise.
  - Go to ACCESS.
- ACCESS:
  - ram_addr and ram_din driven from the latched registers.
  - ram_we = 1 only in the first ACCESS cycle, and only for a RAM write.
  - Counter decrements each cycle; leave for RESP when it reaches 0.
  - On that final cycle, register read data (ram_dout or the IO mux) into data_to_cpu, and commit IO register writes.
- RESP:
  - mio_ready = 1 for exactly one cycle; data_to_cpu stays valid and holds until the next read completes.
  - Next state is IDLE.
- Latency from the request-accepting edge: mio_ready rises after RAM_LAT+1 cycles for RAM, after 2 cycles for IO/unmapped.
- Back-to-back requests: minimum one IDLE cycle between requests. Inputs are ignored outside IDLE, so the CPU must hold them stable until mio_ready.
- A write completion leaves data_to_cpu unchanged.
- Reset, including mid-transaction:
  - State returns to IDLE.
  - mio_ready = 0, ram_we = 0, data_to_cpu = 0, led_out = 0, disp_out = 0, ram_addr = 0, ram_din = 0.
  - No pending write is committed after reset asserts.

Optional Feature:
- Macro: MIO_COUNTER_EN.
- Defined:
  - 32-bit free-running counter, increments every clk, resets to 0.
  - Read at 0xF000_0004 returns the value sampled in the final ACCESS cycle.
  - Write loads data_from_cpu; if a write and an increment coincide, the write wins and the next cycle increments from the loaded value.
- Undefined: 0xF000_0004 behaves as unmapped (reads 0, writes ignored), and no counter flops exist.

Decomposition:
- Package mio_pkg holds:
  - Base-address constants: RAM_BASE, DISP_ADDR, GPIO_ADDR, CNT_ADDR.
  - Target enum: TGT_RAM, TGT_DISP, TGT_GPIO, TGT_CNT, TGT_NONE.
  - State enum: S_IDLE, S_ACCESS, S_RESP.
- One combinational sub-module, mio_addr_decode: addr → target enum + RAM word address.

Test Plan:
- RAM_LAT = 2. Write 0xDEADBEEF to 0x0000_0010:
  - ram_we pulses once with ram_addr = 4.
  - mio_ready is high exactly 3 cycles after the accepting edge, for 1 cycle.
  - A subsequent read of 0x10 returns 0xDEADBEEF on data_to_cpu while mio_ready = 1.
- sw_in = 0x00A5, read 0xF000_0000 → data_to_cpu = 0x0000_00A5, mio_ready 2 cycles after accept. Write 0x1FF → led_out = 0xFF (LED_W = 8).
- Write 0x12345678 to 0xE000_0000 → disp_out = 0x12345678. Read 0x8000_0000 → data_to_cpu = 0 and mio_ready still pulses.
- Assert reset during ACCESS of a write to 0xE000_0000 → disp_out = 0, no mio_ready, state IDLE, and the next request completes normally.
- MIO_COUNTER_EN defined:
  - Write 0x100 to 0xF000_0004, then read 4 cycles later → read value is 0x100 + elapsed cycles (bench computes exactly).
  - Without the macro, the same read returns 0.
- Hold cpu_mio high across two accesses (CPU's next state) → two distinct mio_ready pulses separated by at least one IDLE cycle; the second uses the newly presented address.
